// File: rtl/adc_axis_packer.sv
// Packs 12-bit ADC samples two per 32-bit word into an FWFT FIFO feeding an
// AXI4-Stream master, and runs the end-of-frame done-clear handshake.
module adc_axis_packer #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        i_CMOS_Clk,
    input  logic        i_Rst_n,
    input  logic [11:0] i_Sample,
    input  logic        i_Sample_Valid,
    input  logic        i_Sample_Last,
    input  logic        i_ADC_Done,
    output logic        o_Done_Clean,
    output logic [31:0] o_M_Axis_Tdata,
    output logic [3:0]  o_M_Axis_Tkeep,
    output logic        o_M_Axis_Tlast,
    output logic        o_M_Axis_Tvalid,
    input  logic        i_M_Axis_Tready,
    output logic        o_Overflow,
    input  logic        i_Clear_Err,
    output logic [15:0] o_Word_Count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 37;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            lane_odd_q, lane_odd_d;
    logic [11:0]     held_q, held_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     word_count_q, word_count_d;
    logic            done_clean_q, done_clean_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            handshake;
    logic [EW-1:0]   head;
    logic            word_vld;
    logic [EW-1:0]   word;
    logic            wr_en;
    logic            drop;

    // FWFT head drives the stream; payload forced to zero while empty
    assign fifo_empty      = (count_q == CW'(0));
    assign fifo_full       = (count_q == CW'(FIFO_DEPTH));
    assign head            = mem_q[rd_ptr_q];
    assign handshake       = ~fifo_empty & i_M_Axis_Tready;
    assign o_M_Axis_Tvalid = ~fifo_empty;
    assign o_M_Axis_Tdata  = fifo_empty ? 32'h0 : head[36:5];
    assign o_M_Axis_Tkeep  = fifo_empty ? 4'h0  : head[4:1];
    assign o_M_Axis_Tlast  = fifo_empty ? 1'b0  : head[0];
    assign o_Overflow      = overflow_q;
    assign o_Word_Count    = word_count_q;
    assign o_Done_Clean    = done_clean_q;

    // Lane packing, FIFO bookkeeping and frame state machine
    always_comb begin
        state_d      = state_q;
        lane_odd_d   = lane_odd_q;
        held_d       = held_q;
        word_vld     = 1'b0;
        word         = '0;
        wr_en        = 1'b0;
        drop         = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        done_clean_d = 1'b0;

        if (state_q == ST_RUN && i_Sample_Valid) begin
            if (lane_odd_q) begin
                word_vld   = 1'b1;
                word       = {4'h0, i_Sample, 4'h0, held_q, 4'hF, i_Sample_Last};
                lane_odd_d = 1'b0;
            end else if (i_Sample_Last) begin
                word_vld = 1'b1;
                word     = {16'h0, 4'h0, i_Sample, 4'h3, 1'b1};
            end else begin
                held_d     = i_Sample;
                lane_odd_d = 1'b1;
            end
        end

        // A full FIFO still takes a word when its head leaves this cycle
        wr_en = word_vld & (~fifo_full | handshake);
        drop  = word_vld & ~wr_en;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (handshake) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (word_count_q != 16'hFFFF) begin
                word_count_d = word_count_q + 16'd1;
            end
        end
        count_d = count_q + CW'(wr_en) - CW'(handshake);

        unique case (state_q)
            ST_RUN: begin
                if (word_vld && word[0]) begin
                    state_d = wr_en ? ST_DRAIN : ST_CLEAN;
                end
            end
            ST_DRAIN: begin
                if (handshake && head[0]) begin
                    state_d = ST_CLEAN;
                end
            end
            ST_CLEAN: begin
                if (!i_ADC_Done) begin
                    state_d      = ST_RUN;
                    word_count_d = 16'h0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (drop || (state_q != ST_RUN && i_Sample_Valid)) begin
            overflow_d = 1'b1;
        end else if (i_Clear_Err) begin
            overflow_d = 1'b0;
        end

        done_clean_d = (state_d == ST_CLEAN);
    end

    always_ff @(posedge i_CMOS_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= ST_RUN;
            lane_odd_q   <= 1'b0;
            held_q       <= 12'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            word_count_q <= 16'h0;
            done_clean_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_odd_q   <= lane_odd_d;
            held_q       <= held_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            done_clean_q <= done_clean_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every read
    always_ff @(posedge i_CMOS_Clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: queue-based frame model checked every cycle,
// plus directed frames with hand-computed words.
module tb_adc_axis_packer;

    localparam int DEPTH   = 16;
    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_CLEAN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample = 12'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        adc_done = 1'b1;
    logic        done_clean;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        overflow;
    logic        clear_err = 1'b0;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    adc_axis_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .i_CMOS_Clk      (clk),
        .i_Rst_n         (rst_n),
        .i_Sample        (sample),
        .i_Sample_Valid  (s_valid),
        .i_Sample_Last   (s_last),
        .i_ADC_Done      (adc_done),
        .o_Done_Clean    (done_clean),
        .o_M_Axis_Tdata  (tdata),
        .o_M_Axis_Tkeep  (tkeep),
        .o_M_Axis_Tlast  (tlast),
        .o_M_Axis_Tvalid (tvalid),
        .i_M_Axis_Tready (tready),
        .o_Overflow      (overflow),
        .i_Clear_Err     (clear_err),
        .o_Word_Count    (word_count)
    );

    always #5 clk = ~clk;

    // Frame model: queue of {data, keep, last}, a held half-word, a frame phase
    logic [36:0] m_q [$];
    logic [11:0] m_half = 12'h0;
    bit          m_half_v = 1'b0;
    int          m_ph = P_RUN;
    bit          m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0;
    logic [36:0] m_w, m_head;
    bit          m_hs, m_space, m_set, m_have;
    int          m_nph;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_half_v = 1'b0;
            m_ph     = P_RUN;
            m_ovf    = 1'b0;
            m_cnt    = 16'h0;
        end else begin
            m_hs    = (m_q.size() != 0) && tready;
            m_space = (m_q.size() < DEPTH) || m_hs;
            m_nph   = m_ph;
            m_set   = 1'b0;
            if (m_hs) begin
                m_head = m_q.pop_front();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_ph == P_DRAIN && m_head[0]) m_nph = P_CLEAN;
            end
            if (s_valid) begin
                if (m_ph != P_RUN) begin
                    m_set = 1'b1;
                end else begin
                    m_have = 1'b0;
                    if (m_half_v) begin
                        m_w = {4'h0, sample, 4'h0, m_half, 4'hF, s_last};
                        m_have = 1'b1;
                        m_half_v = 1'b0;
                    end else if (s_last) begin
                        m_w = {20'h0, sample, 4'h3, 1'b1};
                        m_have = 1'b1;
                    end else begin
                        m_half = sample;
                        m_half_v = 1'b1;
                    end
                    if (m_have) begin
                        if (m_space) begin
                            m_q.push_back(m_w);
                            if (m_w[0]) m_nph = P_DRAIN;
                        end else begin
                            m_set = 1'b1;
                            if (m_w[0]) m_nph = P_CLEAN;
                        end
                    end
                end
            end
            if (m_ph == P_CLEAN && !adc_done) begin
                m_nph = P_RUN;
                m_cnt = 16'h0;
            end
            m_ph  = m_nph;
            m_ovf = m_set ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
        end
    end

    logic [36:0] got [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [11:0] base, input int first, input int stop,
                         input int total, input int rel);
        for (int i = first; i < stop; i++) begin
            if (i == rel) tready = 1'b1;
            sample  = base + 12'(i);
            s_valid = 1'b1;
            s_last  = (i == total - 1);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && !done_clean; i++) @(negedge clk);
        chk("done_clean_timeout", done_clean, 1'b1);
    endtask

    task automatic rearm();
        adc_done = 1'b0;
        @(negedge clk);
        adc_done = 1'b1;
        chk("rearm_done_clean", done_clean, 1'b0);
        chk("rearm_word_count", word_count, 16'h0);
    endtask

    task automatic clear_overflow();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("overflow_cleared", overflow, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tvalid"}, tvalid, 1'b0);
        chk({tag, "_tdata"}, tdata, 32'h0);
        chk({tag, "_tkeep"}, tkeep, 4'h0);
        chk({tag, "_tlast"}, tlast, 1'b0);
        chk({tag, "_done"}, done_clean, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_wcnt"}, word_count, 16'h0);
    endtask

    logic [31:0] e1 [4];

    initial begin
        fork
            forever begin
                @(posedge clk);
                if (rst_n && tvalid && tready) got.push_back({tdata, tkeep, tlast});
            end
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("tvalid", tvalid, m_q.size() != 0);
                    if (m_q.size() != 0) begin
                        chk("tdata", tdata, m_q[0][36:5]);
                        chk("tkeep", tkeep, m_q[0][4:1]);
                        chk("tlast", tlast, m_q[0][0]);
                    end
                    chk("overflow", overflow, m_ovf);
                    chk("done_clean", done_clean, m_ph == P_CLEAN);
                    chk("word_count", word_count, m_cnt);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 8 samples, sink always ready
        got.delete();
        drive(12'h000, 0, 8, 8, -1);
        idle();
        wait_done(50);
        e1 = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006};
        chk("f1_words", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            chk("f1_data", got[k][36:5], e1[k]);
            chk("f1_keep", got[k][4:1], 4'hF);
            chk("f1_last", got[k][0], k == 3);
        end
        chk("f1_wcnt", word_count, 16'd4);
        repeat (2) @(negedge clk);
        chk("f1_done_held", done_clean, 1'b1);
        rearm();

        // odd-length frame, then a short frame to prove lane 0 restart
        got.delete();
        drive(12'h100, 0, 5, 5, -1);
        idle();
        wait_done(50);
        rearm();
        drive(12'h200, 0, 2, 2, -1);
        idle();
        wait_done(50);
        chk("f2_words", got.size(), 4);
        if (got.size() == 4) begin
            chk("f2_w1", got[1][36:5], 32'h01030102);
            chk("f2_tail_data", got[2][36:5], 32'h00000104);
            chk("f2_tail_keep", got[2][4:1], 4'h3);
            chk("f2_tail_last", got[2][0], 1'b1);
            chk("f3_lane0", got[3][36:5], 32'h02010200);
        end
        rearm();

        // 40-cycle stall in a 64-sample frame overflows the FIFO
        got.delete();
        tready = 1'b0;
        drive(12'h300, 0, 30, 64, -1);
        chk("stall_tvalid", tvalid, 1'b1);
        chk("stall_tdata", tdata, 32'h03010300);
        drive(12'h300, 30, 64, 64, 40);
        idle();
        wait_done(100);
        chk("stall_ovf", overflow, 1'b1);
        chk("stall_words", got.size(), 28);
        chk("stall_wcnt", word_count, 16'd28);
        if (got.size() == 28) begin
            chk("stall_w15", got[15][36:5], 32'h031F031E);
            chk("stall_w16", got[16][36:5], 32'h03290328);
            chk("stall_tlast", got[27][0], 1'b1);
        end
        rearm();
        clear_overflow();

        // full FIFO, handshake and completing sample in the same cycle
        got.delete();
        tready = 1'b0;
        drive(12'h400, 0, 34, 34, 33);
        idle();
        wait_done(60);
        chk("full_hs_ovf", overflow, 1'b0);
        chk("full_hs_words", got.size(), 17);
        if (got.size() == 17) chk("full_hs_last", got[16], {32'h04210420, 4'hF, 1'b1});
        rearm();

        // sample strobe while draining
        got.delete();
        tready = 1'b0;
        drive(12'h500, 0, 2, 2, -1);
        drive(12'h5FF, 0, 1, 100, -1);
        idle();
        @(negedge clk);
        chk("drain_ovf", overflow, 1'b1);
        tready = 1'b1;
        wait_done(50);
        chk("drain_words", got.size(), 1);
        if (got.size() == 1) chk("drain_word", got[0][36:5], 32'h05010500);
        rearm();
        clear_overflow();

        // reset mid-frame with 3 words buffered and a half-word held
        got.delete();
        tready = 1'b0;
        drive(12'h700, 0, 7, 100, -1);
        idle();
        chk("pre_rst_tvalid", tvalid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("midrst");
        rst_n  = 1'b1;
        tready = 1'b1;
        drive(12'h600, 0, 2, 2, -1);
        idle();
        wait_done(50);
        chk("post_rst_words", got.size(), 1);
        if (got.size() == 1) chk("post_rst_word", got[0], {32'h06010600, 4'hF, 1'b1});
        rearm();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
